// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin I/D arbiter onto one single-port memory (optional stats: ARB_STATS_EN)
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int RSP_DEPTH       = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        i_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] i_rsp_data,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    input  logic [3:0]  d_req_byte_en,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rsp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic [3:0]  mem_req_byte_en,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data
`ifdef ARB_STATS_EN
    ,
    output logic [31:0] stat_i_grants,
    output logic [31:0] stat_d_grants,
    output logic [31:0] stat_conflicts,
    output logic [31:0] stat_stall_cycles
`endif
);
    localparam int TW  = $clog2(MAX_OUTSTANDING);
    localparam int CW  = TW + 1;
    localparam int RPW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int RCW = $clog2(RSP_DEPTH) + 1;

    typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} port_t;

    port_t          last_grant;
    logic           tag_mem [MAX_OUTSTANDING];
    logic [TW-1:0]  tag_wr, tag_rd;
    logic [CW-1:0]  tag_cnt;
    logic [CW-1:0]  out_cnt [2];
    logic [31:0]    rsp_mem [2][RSP_DEPTH];
    logic [RPW-1:0] rsp_wr [2];
    logic [RPW-1:0] rsp_rd [2];
    logic [RCW-1:0] rsp_cnt [2];

    logic [1:0] req_valid, elig, issue_p, rsp_push, rsp_pop, rsp_ready;
    logic       sel_d, issue, rsp_arrive;

    assign req_valid = {d_req_valid, i_req_valid};
    assign rsp_ready = {d_rsp_ready, i_rsp_ready};

    // A port is only eligible if its response is guaranteed a slot when it returns.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            elig[p] = req_valid[p]
                && ((32'(out_cnt[p]) + 32'(rsp_cnt[p])) < 32'(RSP_DEPTH))
                && (32'(tag_cnt) < 32'(MAX_OUTSTANDING));
        end
    end

    assign sel_d         = elig[1] && (!elig[0] || last_grant == GRANT_I);
    assign mem_req_valid = |elig;
    assign issue         = mem_req_valid && mem_req_ready;
    assign issue_p       = {issue && sel_d, issue && !sel_d};
    assign i_req_ready   = elig[0] && !sel_d && mem_req_ready;
    assign d_req_ready   = sel_d && mem_req_ready;

    assign mem_req_addr    = sel_d ? d_req_addr : (elig[0] ? i_req_addr : 32'h0);
    assign mem_req_byte_en = sel_d ? d_req_byte_en : 4'h0;
    assign mem_req_wdata   = sel_d ? d_req_wdata : 32'h0;

    assign rsp_arrive = mem_rsp_valid && (tag_cnt != '0);
    assign rsp_push   = {rsp_arrive && tag_mem[tag_rd], rsp_arrive && !tag_mem[tag_rd]};

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rsp_pop[p] = (rsp_cnt[p] != '0) && rsp_ready[p];
        end
    end

    assign i_rsp_valid = (rsp_cnt[0] != '0);
    assign d_rsp_valid = (rsp_cnt[1] != '0);
    assign i_rsp_data  = i_rsp_valid ? rsp_mem[0][rsp_rd[0]] : 32'h0;
    assign d_rsp_data  = d_rsp_valid ? rsp_mem[1][rsp_rd[1]] : 32'h0;

    // Storage arrays carry no reset; their validity is tracked by the counters.
    always_ff @(posedge CLK) begin
        if (issue) tag_mem[tag_wr] <= sel_d;
        for (int p = 0; p < 2; p++) begin
            if (rsp_push[p]) rsp_mem[p][rsp_wr[p]] <= mem_rsp_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant <= GRANT_D;
            tag_wr     <= '0;
            tag_rd     <= '0;
            tag_cnt    <= '0;
            for (int p = 0; p < 2; p++) begin
                out_cnt[p] <= '0;
                rsp_wr[p]  <= '0;
                rsp_rd[p]  <= '0;
                rsp_cnt[p] <= '0;
            end
        end else begin
            if (issue) begin
                last_grant <= sel_d ? GRANT_D : GRANT_I;
                tag_wr     <= tag_wr + 1'b1;
            end
            if (rsp_arrive) tag_rd <= tag_rd + 1'b1;
            tag_cnt <= tag_cnt + CW'(issue) - CW'(rsp_arrive);
            for (int p = 0; p < 2; p++) begin
                out_cnt[p] <= out_cnt[p] + CW'(issue_p[p]) - CW'(rsp_push[p]);
                rsp_cnt[p] <= rsp_cnt[p] + RCW'(rsp_push[p]) - RCW'(rsp_pop[p]);
                if (rsp_push[p])
                    rsp_wr[p] <= (rsp_wr[p] == RPW'(RSP_DEPTH - 1)) ? '0 : rsp_wr[p] + 1'b1;
                if (rsp_pop[p])
                    rsp_rd[p] <= (rsp_rd[p] == RPW'(RSP_DEPTH - 1)) ? '0 : rsp_rd[p] + 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (!RST && mem_rsp_valid && tag_cnt == '0)
            $display("mem_port_arbiter: error: memory response with no outstanding request ignored");
    end
`endif

`ifdef ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_i_grants     <= '0;
            stat_d_grants     <= '0;
            stat_conflicts    <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (issue_p[0]) stat_i_grants <= stat_i_grants + 1'b1;
            if (issue_p[1]) stat_d_grants <= stat_d_grants + 1'b1;
            if (i_req_valid && d_req_valid) stat_conflicts <= stat_conflicts + 1'b1;
            if ((i_req_valid || d_req_valid) && !issue) stat_stall_cycles <= stat_stall_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        CLK = 1'b0;
    logic        RST;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready;
    logic [31:0] i_req_addr, i_rsp_data;
    logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
    logic [3:0]  d_req_byte_en;
    logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
    logic [3:0]  mem_req_byte_en;
`ifdef ARB_STATS_EN
    logic [31:0] stat_i_grants, stat_d_grants, stat_conflicts, stat_stall_cycles;
`endif

    int vecs = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.MAX_OUTSTANDING(4), .RSP_DEPTH(2)) dut (
        .CLK(CLK), .RST(RST),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_byte_en(d_req_byte_en), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_byte_en(mem_req_byte_en), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
`ifdef ARB_STATS_EN
        ,
        .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
        .stat_conflicts(stat_conflicts), .stat_stall_cycles(stat_stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven at posedge+1 and checked at posedge+2.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        i_req_valid = 0; i_req_addr = 0; i_rsp_ready = 1;
        d_req_valid = 0; d_req_addr = 0; d_req_byte_en = 0; d_req_wdata = 0; d_rsp_ready = 1;
        mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_data = 0;
        tick(); tick();
        RST = 1'b0;
        #1;
        chk("reset i_rsp_valid", 32'(i_rsp_valid), 32'd0);
        chk("reset d_rsp_valid", 32'(d_rsp_valid), 32'd0);
        chk("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("reset i_req_ready", 32'(i_req_ready), 32'd0);
        chk("reset d_req_ready", 32'(d_req_ready), 32'd0);
        chk("reset i_rsp_data", i_rsp_data, 32'h0);
        chk("reset mem_req_addr", mem_req_addr, 32'h0);
        tick();

        // Both ports valid with 1-cycle memory: grants alternate I,D,... starting with I.
        for (int c = 0; c < 9; c++) begin
            i_req_valid = (c < 8); i_req_addr = 32'h1000 + 32'(c);
            d_req_valid = (c < 8); d_req_addr = 32'h2000 + 32'(c);
            mem_rsp_valid = (c >= 1); mem_rsp_data = 32'h0 + 32'(c);
            #1;
            if (c < 8) begin
                chk($sformatf("alt i_req_ready c%0d", c), 32'(i_req_ready), 32'((c % 2) == 0));
                chk($sformatf("alt d_req_ready c%0d", c), 32'(d_req_ready), 32'((c % 2) == 1));
            end
            tick();
        end
        mem_rsp_valid = 0;
`ifdef ARB_STATS_EN
        #1;
        chk("stat_i_grants", stat_i_grants, 32'd4);
        chk("stat_d_grants", stat_d_grants, 32'd4);
        chk("stat_conflicts", stat_conflicts, 32'd8);
        chk("stat_stall_cycles", stat_stall_cycles, 32'd0);
`endif
        tick(); tick();
        chk("alt drained i", 32'(i_rsp_valid), 32'd0);
        chk("alt drained d", 32'(d_rsp_valid), 32'd0);

        // Single I read, first presented while memory is not ready.
        i_req_valid = 1; i_req_addr = 32'h100; mem_req_ready = 0;
        #1;
        chk("iread stalled ready", 32'(i_req_ready), 32'd0);
        chk("iread mem_req_valid", 32'(mem_req_valid), 32'd1);
        chk("iread mem_req_addr", mem_req_addr, 32'h100);
        chk("iread mem_req_byte_en", 32'(mem_req_byte_en), 32'd0);
        tick();
        mem_req_ready = 1;
        #1;
        chk("iread ready", 32'(i_req_ready), 32'd1);
        chk("iread d idle", 32'(d_req_ready), 32'd0);
        tick();
        i_req_valid = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hDEADBEEF;
        #1;
        chk("iread rsp not yet", 32'(i_rsp_valid), 32'd0);
        tick();
        mem_rsp_valid = 0;
        #1;
        chk("iread rsp valid", 32'(i_rsp_valid), 32'd1);
        chk("iread rsp data", i_rsp_data, 32'hDEADBEEF);
        chk("iread d rsp idle", 32'(d_rsp_valid), 32'd0);
        tick();
        chk("iread rsp consumed", 32'(i_rsp_valid), 32'd0);

        // D partial write.
        d_req_valid = 1; d_req_addr = 32'h40; d_req_byte_en = 4'b0011; d_req_wdata = 32'h1234ABCD;
        #1;
        chk("dwr d_req_ready", 32'(d_req_ready), 32'd1);
        chk("dwr mem addr", mem_req_addr, 32'h40);
        chk("dwr mem byte_en", 32'(mem_req_byte_en), 32'h3);
        chk("dwr mem wdata", mem_req_wdata, 32'h1234ABCD);
        tick();
        d_req_valid = 0; d_req_byte_en = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE0001;
        tick();
        mem_rsp_valid = 0;
        #1;
        chk("dwr rsp valid", 32'(d_rsp_valid), 32'd1);
        chk("dwr rsp data", d_rsp_data, 32'hCAFE0001);
        tick();
        chk("dwr rsp once", 32'(d_rsp_valid), 32'd0);

        // I response backpressure: credits run out for I while D still proceeds.
        i_rsp_ready = 0;
        i_req_valid = 1; i_req_addr = 32'h200;
        #1;
        chk("bp i issue0", 32'(i_req_ready), 32'd1);
        tick();
        i_req_addr = 32'h204; mem_rsp_valid = 1; mem_rsp_data = 32'h11111111;
        #1;
        chk("bp i issue1", 32'(i_req_ready), 32'd1);
        tick();
        mem_rsp_data = 32'h22222222; d_req_valid = 1; d_req_addr = 32'h300;
        #1;
        chk("bp i blocked", 32'(i_req_ready), 32'd0);
        chk("bp d proceeds", 32'(d_req_ready), 32'd1);
        tick();
        d_req_valid = 0; mem_rsp_data = 32'h33333333;
        #1;
        chk("bp mem idle", 32'(mem_req_valid), 32'd0);
        chk("bp i head", i_rsp_data, 32'h11111111);
        tick();
        mem_rsp_valid = 0; i_req_valid = 0;
        #1;
        chk("bp d rsp data", d_rsp_data, 32'h33333333);
        chk("bp i head held", i_rsp_data, 32'h11111111);
        i_rsp_ready = 1;
        tick();
        chk("bp i second", i_rsp_data, 32'h22222222);
        tick();
        chk("bp i drained", 32'(i_rsp_valid), 32'd0);

        // Delayed memory: exactly MAX_OUTSTANDING issues, then nothing.
        for (int c = 0; c < 6; c++) begin
            i_req_valid = 1; d_req_valid = 1;
            #1;
            chk($sformatf("maxo mem_req_valid c%0d", c), 32'(mem_req_valid), 32'(c < 4));
            chk($sformatf("maxo i_req_ready c%0d", c), 32'(i_req_ready), 32'(c < 4 && (c % 2) == 0));
            tick();
        end
        i_req_valid = 0; d_req_valid = 0;
        for (int k = 0; k < 4; k++) begin
            mem_rsp_valid = 1; mem_rsp_data = 32'hA0 + 32'(k);
            #1;
            if (k == 1) chk("maxo first rsp", i_rsp_data, 32'hA0);
            tick();
        end
        mem_rsp_valid = 0;
        tick(); tick();

        // Reset with requests outstanding and a queued response.
        i_rsp_ready = 0;
        i_req_valid = 1; d_req_valid = 1;
        tick();
        tick();
        d_req_valid = 0;
        #1;
        chk("rst pre i issue", 32'(i_req_ready), 32'd1);
        tick();
        i_req_valid = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h55;
        tick();
        mem_rsp_valid = 0;
        #1;
        chk("rst pre queued", 32'(i_rsp_valid), 32'd1);
        RST = 1;
        tick();
        RST = 0;
        #1;
        chk("rst i_rsp_valid", 32'(i_rsp_valid), 32'd0);
        chk("rst d_rsp_valid", 32'(d_rsp_valid), 32'd0);
        chk("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
`ifdef ARB_STATS_EN
        chk("rst stat_i_grants", stat_i_grants, 32'd0);
`endif
        i_req_valid = 1; d_req_valid = 1;
        #1;
        chk("rst first grant i", 32'(i_req_ready), 32'd1);
        chk("rst first grant not d", 32'(d_req_ready), 32'd0);
        tick();
        i_req_valid = 0; d_req_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port external memory between the core's instruction-fetch requester (I) and data requester (D).
- Replaces the dual-port ext_mem hookup in the UART top level, so the design can target a single-port BRAM/SRAM.
- Grants requests round-robin and tracks outstanding transactions in an in-order tag FIFO.
- Steers each memory response into that requester's response FIFO. Responses are never dropped; a requester is only granted when space for its response is reserved.

Parameters:
- MAX_OUTSTANDING, 4, maximum number of issued-but-unreturned memory requests (power of 2, 2..16).
- RSP_DEPTH, 2, depth of each per-port response FIFO (power of 2, 1..8).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- i_req_valid  in  1  I request valid.
- i_req_ready  out  1  I request accepted this cycle.
- i_req_addr  in  32  I byte address (read only).
- i_rsp_valid  out  1  I response available.
- i_rsp_ready  in  1  I response consumed.
- i_rsp_data  out  32  I read data.
- d_req_valid  in  1  D request valid.
- d_req_ready  out  1  D request accepted this cycle.
- d_req_addr  in  32  D byte address.
- d_req_byte_en  in  4  write byte enables; 4'b0000 means read.
- d_req_wdata  in  32  write data.
- d_rsp_valid  out  1  D response available (reads and writes both respond).
- d_rsp_ready  in  1  D response consumed.
- d_rsp_data  out  32  read data; for writes, the value returned by memory.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  32  memory address.
- mem_req_byte_en  out  4  memory byte enables.
- mem_req_wdata  out  32  memory write data.
- mem_rsp_valid  in  1  memory response, in request order, one per request, no backpressure.
- mem_rsp_data  in  32  memory response data.

Behaviour:
- Handshakes: a transfer occurs when valid && ready on the same posedge. Valid must not depend combinationally on ready. mem_req_* is a combinational mux of the granted port; req_ready is asserted only to the granted port, and only while mem_req_ready is high.
- Eligibility: port P is eligible when P_req_valid && outstanding_P + count(rsp_fifo_P) < RSP_DEPTH && total_outstanding < MAX_OUTSTANDING.
- Arbitration: round-robin with a last_grant bit (reset = D, so I wins the first tie).
  - If both are eligible, grant the port other than last_grant.
  - If one is eligible, grant it.
  - last_grant updates only on an accepted memory handshake. A presented request that is not accepted does not move the pointer.
- Tag FIFO: depth MAX_OUTSTANDING, 1-bit port id. Push on mem request handshake; pop on mem_rsp_valid.
  - Push and pop in the same cycle are both allowed; the count is unchanged.
  - mem_rsp_valid with the tag FIFO empty is a protocol error. Ignore the response and, under simulation, $display an error.
- Response FIFOs: on mem_rsp_valid, push mem_rsp_data into the FIFO of the popped tag. Push is guaranteed by the eligibility credit rule, so overflow is impossible. P_rsp_valid = FIFO non-empty; data is the FIFO head. Simultaneous push and pop are allowed.
- Latency: zero cycles request pass-through when granted and mem_req_ready is high. A response is visible on P_rsp_valid 1 cycle after mem_rsp_valid.
- Counters: outstanding_P increments on issue and decrements on response arrival. Width is clog2(MAX_OUTSTANDING)+1. No wrap is possible, because the credit rule caps the counts.
- Reset:
  - Tag FIFO and both response FIFOs emptied; all counters cleared; last_grant = D.
  - Outputs after reset: i/d_req_ready = 0 unless the request is valid and mem ready; i/d_rsp_valid = 0; mem_req_valid = 0; data outputs = 0.
  - Reset mid-transaction discards in-flight tags. The memory must be reset in the same cycle.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds outputs stat_i_grants[31:0], stat_d_grants[31:0], stat_conflicts[31:0] and stat_stall_cycles[31:0].
  - stat_i_grants / stat_d_grants count grants per port.
  - stat_conflicts counts cycles with both ports valid.
  - stat_stall_cycles counts cycles with any valid request and no memory handshake.
  - All four are cleared by RST and wrap modulo 2^32.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Single I read: i_req addr 0x100, memory returns 0xDEADBEEF 1 cycle later -> i_rsp_valid one cycle after mem_rsp_valid with data 0xDEADBEEF; D side stays idle.
- Both valid continuously, mem_req_ready=1 -> grants alternate I,D,I,D starting with I. With ARB_STATS_EN, after 8 cycles stat_i_grants=4, stat_d_grants=4, stat_conflicts=8.
- D write byte_en 4'b0011 addr 0x40 wdata 0x1234ABCD -> mem sees the exact byte_en/addr/wdata, and d_rsp_valid returns once.
- Hold i_rsp_ready=0 with RSP_DEPTH=2 -> after 2 I responses are queued, i_req_ready stays 0 while D requests still proceed. Releasing i_rsp_ready drains I in order.
- MAX_OUTSTANDING=4, memory delays all responses -> exactly 4 issues, then mem_req_valid=0 until the first response returns.
- Assert RST with 3 requests outstanding -> next cycle all rsp_valid=0, counters 0, and the first grant after reset goes to I.
